// File: rtl/lz77_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module : lz77_search_scheduler
// Brief  : Buffers lookahead bytes, drives the pattern search, emits LZ77 tokens
//          and commits consumed bytes to the search history.
// Rev    : 1.0
// ============================================================================
module lz77_search_scheduler #(
    parameter int HISTORY_DEPTH = 4096,
    parameter int INDEX_WIDTH   = 12,
    parameter int MAX_PATTERN   = 7,
    parameter int LEN_WIDTH     = 3,
    parameter int MIN_MATCH     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inDataValid,
    output logic                     inDataReady,
    input  logic [7:0]               inData,
    input  logic                     inDataLast,
    output logic                     searchWriteDataValid,
    input  logic                     searchWriteDataReady,
    output logic [7:0]               searchWriteData,
    output logic                     searchPatternValid,
    input  logic                     searchPatternReady,
    output logic [8*MAX_PATTERN-1:0] searchPatternData,
    output logic [LEN_WIDTH-1:0]     searchPatternLength,
    input  logic                     searchResultValid,
    output logic                     searchResultReady,
    input  logic [INDEX_WIDTH-1:0]   searchResultIndex,
    input  logic [LEN_WIDTH-1:0]     searchResultLength,
    output logic                     tokenValid,
    input  logic                     tokenReady,
    output logic                     tokenIsMatch,
    output logic [7:0]               tokenLiteral,
    output logic [INDEX_WIDTH-1:0]   tokenIndex,
    output logic [LEN_WIDTH-1:0]     tokenLength,
    output logic                     tokenLast,
    output logic                     busy
);
    localparam int HIST_W = $clog2(HISTORY_DEPTH + 1);
    localparam int LA_W   = 8 * MAX_PATTERN;

    localparam logic [2:0] S_FILL   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [LA_W-1:0]        la_q, la_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   last_seen_q, last_seen_d;
    logic [HIST_W-1:0]      hist_q, hist_d;
    logic                   tok_match_q, tok_match_d;
    logic [7:0]             tok_lit_q, tok_lit_d;
    logic [INDEX_WIDTH-1:0] tok_idx_q, tok_idx_d;
    logic [LEN_WIDTH-1:0]   tok_len_q, tok_len_d;
    logic                   tok_last_q, tok_last_d;
    logic [LEN_WIDTH-1:0]   res_len;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            la_q        <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            last_seen_q <= 1'b0;
            hist_q      <= '0;
            tok_match_q <= 1'b0;
            tok_lit_q   <= '0;
            tok_idx_q   <= '0;
            tok_len_q   <= '0;
            tok_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            la_q        <= la_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            last_seen_q <= last_seen_d;
            hist_q      <= hist_d;
            tok_match_q <= tok_match_d;
            tok_lit_q   <= tok_lit_d;
            tok_idx_q   <= tok_idx_d;
            tok_len_q   <= tok_len_d;
            tok_last_q  <= tok_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        la_d        = la_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        last_seen_d = last_seen_q;
        hist_d      = hist_q;
        tok_match_d = tok_match_q;
        tok_lit_d   = tok_lit_q;
        tok_idx_d   = tok_idx_q;
        tok_len_d   = tok_len_q;
        tok_last_d  = tok_last_q;
        res_len     = (searchResultLength > count_q) ? count_q : searchResultLength;
        case (state_q)
            S_FILL: begin
                if (inDataReady && inDataValid) begin
                    for (int i = 0; i < MAX_PATTERN; i++) begin
                        if (count_q == LEN_WIDTH'(i)) la_d[8*i +: 8] = inData;
                    end
                    count_d     = count_q + 1'b1;
                    last_seen_d = last_seen_q | inDataLast;
                end
                // Next-cycle values let a just-accepted byte start the search immediately.
                if ((count_d == LEN_WIDTH'(MAX_PATTERN)) || (last_seen_d && (count_d != '0))) begin
                    if (hist_q == '0) begin
                        state_d     = S_EMIT;
                        tok_match_d = 1'b0;
                        tok_lit_d   = la_d[7:0];
                        tok_idx_d   = '0;
                        tok_len_d   = LEN_WIDTH'(1);
                        tok_last_d  = last_seen_d && (count_d == LEN_WIDTH'(1));
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if (searchPatternReady) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (searchResultValid) begin
                    state_d = S_EMIT;
                    if (res_len >= LEN_WIDTH'(MIN_MATCH)) begin
                        tok_match_d = 1'b1;
                        tok_lit_d   = '0;
                        tok_idx_d   = searchResultIndex;
                        tok_len_d   = res_len;
                        tok_last_d  = last_seen_q && (res_len == count_q);
                    end else begin
                        tok_match_d = 1'b0;
                        tok_lit_d   = la_q[7:0];
                        tok_idx_d   = '0;
                        tok_len_d   = LEN_WIDTH'(1);
                        tok_last_d  = last_seen_q && (count_q == LEN_WIDTH'(1));
                    end
                end
            end
            S_EMIT: begin
                if (tokenReady) begin
                    state_d     = S_COMMIT;
                    remaining_d = tok_len_q;
                end
            end
            S_COMMIT: begin
                if (searchWriteDataReady) begin
                    la_d        = la_q >> 8;
                    count_d     = count_q - 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (hist_q != HIST_W'(HISTORY_DEPTH)) hist_d = hist_q + 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_FILL;
                        // The page is finished: the next byte starts a fresh history.
                        if (tok_last_q) begin
                            last_seen_d = 1'b0;
                            hist_d      = '0;
                        end
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        inDataReady          = 1'b0;
        searchPatternValid   = 1'b0;
        searchResultReady    = 1'b0;
        tokenValid           = 1'b0;
        searchWriteDataValid = 1'b0;
        case (state_q)
            S_FILL:   inDataReady = reset && (count_q < LEN_WIDTH'(MAX_PATTERN)) && !last_seen_q;
            S_SEARCH: searchPatternValid = 1'b1;
            S_WAIT:   searchResultReady = 1'b1;
            S_EMIT:   tokenValid = 1'b1;
            S_COMMIT: searchWriteDataValid = 1'b1;
            default:  inDataReady = 1'b0;
        endcase
    end

    assign searchPatternData   = la_q;
    assign searchPatternLength = count_q;
    assign searchWriteData     = la_q[7:0];
    assign tokenIsMatch        = tok_match_q;
    assign tokenLiteral        = tok_lit_q;
    assign tokenIndex          = tok_idx_q;
    assign tokenLength         = tok_len_q;
    assign tokenLast           = tok_last_q;
    assign busy                = (state_q != S_FILL) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_lz77_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_lz77_search_scheduler
// Brief  : Directed token table plus random pages against a stream-position model.
// Rev    : 1.0
// ============================================================================
module tb_lz77_search_scheduler;
    logic        clock, reset;
    logic        inDataValid, inDataReady, inDataLast;
    logic [7:0]  inData;
    logic        searchWriteDataValid, searchWriteDataReady;
    logic [7:0]  searchWriteData;
    logic        searchPatternValid, searchPatternReady;
    logic [55:0] searchPatternData;
    logic [2:0]  searchPatternLength;
    logic        searchResultValid, searchResultReady;
    logic [11:0] searchResultIndex;
    logic [2:0]  searchResultLength;
    logic        tokenValid, tokenReady, tokenIsMatch, tokenLast, busy;
    logic [7:0]  tokenLiteral;
    logic [11:0] tokenIndex;
    logic [2:0]  tokenLength;

    lz77_search_scheduler dut (
        .clock(clock), .reset(reset),
        .inDataValid(inDataValid), .inDataReady(inDataReady), .inData(inData), .inDataLast(inDataLast),
        .searchWriteDataValid(searchWriteDataValid), .searchWriteDataReady(searchWriteDataReady),
        .searchWriteData(searchWriteData),
        .searchPatternValid(searchPatternValid), .searchPatternReady(searchPatternReady),
        .searchPatternData(searchPatternData), .searchPatternLength(searchPatternLength),
        .searchResultValid(searchResultValid), .searchResultReady(searchResultReady),
        .searchResultIndex(searchResultIndex), .searchResultLength(searchResultLength),
        .tokenValid(tokenValid), .tokenReady(tokenReady), .tokenIsMatch(tokenIsMatch),
        .tokenLiteral(tokenLiteral), .tokenIndex(tokenIndex), .tokenLength(tokenLength),
        .tokenLast(tokenLast), .busy(busy)
    );

    typedef struct packed {
        logic        srch;
        logic [55:0] pdata;
        logic [2:0]  plen;
        logic [11:0] ridx;
        logic [2:0]  rlen;
        logic        match;
        logic [7:0]  lit;
        logic [11:0] idx;
        logic [2:0]  len;
        logic        last;
        logic [55:0] wdata;
        logic [3:0]  stall;
        logic        wtog;
    } step_t;

    int          checks = 0;
    int          failures = 0;
    int          viol = 0;
    bit          abort = 0;
    logic [8:0]  src_q[$];
    step_t       steps[$];
    step_t       dir[7];

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if ($countones({searchPatternValid, searchResultReady, tokenValid, searchWriteDataValid}) > 1)
            viol = viol + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return searchPatternValid;
            1:       return searchResultReady;
            2:       return tokenValid;
            3:       return searchWriteDataValid;
            default: return inDataReady;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name, output bit saw);
        int t;
        t = 0;
        saw = 0;
        while (!abort && !sig(which)) begin
            if (searchPatternValid) saw = 1;
            @(negedge clock);
            t++;
            if (t > 3000 && !abort) begin
                checks++;
                failures++;
                $display("FAIL %s: timeout, got 0, want 1", name);
                abort = 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit saw;
        if (abort) return;
        inDataValid = 1; inData = b; inDataLast = last;
        wait_for(4, "src_ready", saw);
        @(negedge clock);
        inDataValid = 0; inDataLast = 0;
    endtask

    task automatic run_source(input bit gaps);
        logic [8:0] e;
        while (src_q.size() > 0 && !abort) begin
            e = src_q.pop_front();
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
            send_byte(e[7:0], e[8]);
        end
    endtask

    task automatic apply_step(input step_t s);
        bit saw;
        if (abort) return;
        if (s.srch) begin
            wait_for(0, "srch_wait", saw);
            if (abort) return;
            chk("srch_data", searchPatternData, s.pdata);
            chk("srch_len", searchPatternLength, s.plen);
            searchPatternReady = 1;
            @(negedge clock);
            searchPatternReady = 0;
            searchResultValid = 1; searchResultIndex = s.ridx; searchResultLength = s.rlen;
            wait_for(1, "res_wait", saw);
            @(negedge clock);
            searchResultValid = 0;
        end
        wait_for(2, "tok_wait", saw);
        if (!s.srch) chk("no_search", saw, 0);
        if (abort) return;
        chk("tok_match", tokenIsMatch, s.match);
        chk("tok_len", tokenLength, s.len);
        chk("tok_last", tokenLast, s.last);
        if (s.match) chk("tok_idx", tokenIndex, s.idx);
        else         chk("tok_lit", tokenLiteral, s.lit);
        if (s.stall != 0) begin
            repeat (s.stall) @(negedge clock);
            chk("tok_hold", {tokenValid, tokenIsMatch, tokenLength, tokenLast, s.match ? tokenIndex : 12'(tokenLiteral)},
                {1'b1, s.match, s.len, s.last, s.match ? s.idx : 12'(s.lit)});
        end
        tokenReady = 1;
        @(negedge clock);
        tokenReady = 0;
        for (int i = 0; i < int'(s.len); i++) begin
            if (s.wtog) @(negedge clock);
            wait_for(3, "wr_wait", saw);
            if (abort) return;
            chk("wr_data", searchWriteData, s.wdata[8*i +: 8]);
            searchWriteDataReady = 1;
            @(negedge clock);
            searchWriteDataReady = 0;
        end
    endtask

    function automatic step_t mk(input logic srch, input logic [55:0] pd, input logic [2:0] pl,
                                 input logic [11:0] ri, input logic [2:0] rl, input logic m,
                                 input logic [7:0] lit, input logic [11:0] idx, input logic [2:0] len,
                                 input logic last, input logic [55:0] wd, input logic [3:0] stall,
                                 input logic wtog);
        step_t s;
        s = '0;
        s.srch = srch; s.pdata = pd; s.plen = pl; s.ridx = ri; s.rlen = rl; s.match = m;
        s.lit = lit; s.idx = idx; s.len = len; s.last = last; s.wdata = wd; s.stall = stall; s.wtog = wtog;
        return s;
    endfunction

    // Reference: walk each page by stream position; lookahead is the next min(7, left) bytes.
    task automatic build_random();
        int         lens[6];
        logic [7:0] b[$];
        int         p, n, L, rl;
        step_t      s;
        lens[0] = 1; lens[1] = 7; lens[2] = 8;
        lens[3] = $urandom_range(1, 30); lens[4] = $urandom_range(1, 30); lens[5] = $urandom_range(2, 40);
        for (int pg = 0; pg < 6; pg++) begin
            b.delete();
            for (int k = 0; k < lens[pg]; k++) begin
                b.push_back(8'($urandom_range(0, 255)));
                src_q.push_back({(k == lens[pg] - 1), b[k]});
            end
            p = 0;
            while (p < lens[pg]) begin
                s = '0;
                n = (lens[pg] - p > 7) ? 7 : lens[pg] - p;
                if (p == 0) begin
                    L = 1;
                    s.lit = b[0];
                end else begin
                    s.srch = 1;
                    s.plen = 3'(n);
                    for (int k = 0; k < n; k++) s.pdata[8*k +: 8] = b[p + k];
                    s.ridx = 12'($urandom_range(0, 4095));
                    s.rlen = 3'($urandom_range(0, 7));
                    rl = int'(s.rlen);
                    L = (rl > n) ? n : rl;
                    if (L >= 2) begin
                        s.match = 1;
                        s.idx = s.ridx;
                    end else begin
                        L = 1;
                        s.lit = b[p];
                    end
                end
                s.len = 3'(L);
                s.last = (p + L == lens[pg]);
                for (int k = 0; k < L; k++) s.wdata[8*k +: 8] = b[p + k];
                s.stall = 4'($urandom_range(0, 3));
                s.wtog = 1'($urandom_range(0, 1));
                steps.push_back(s);
                p = p + L;
            end
        end
    endtask

    initial begin
        bit saw;
        clock = 0; reset = 0;
        inDataValid = 0; inData = 0; inDataLast = 0;
        searchWriteDataReady = 0; searchPatternReady = 0;
        searchResultValid = 0; searchResultIndex = 0; searchResultLength = 0; tokenReady = 0;
        repeat (2) @(negedge clock);
        chk("rst_valids", {searchPatternValid, searchResultReady, tokenValid, searchWriteDataValid}, 0);
        chk("rst_in_ready", inDataReady, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tok", {tokenIsMatch, tokenLiteral, tokenIndex, tokenLength, tokenLast}, 0);
        reset = 1;
        @(negedge clock);
        chk("idle_in_ready", inDataReady, 1);

        // Page A: 0x41..0x4A (10 bytes), page B: 0x45 0xFC 0x45.
        for (int k = 0; k < 10; k++) src_q.push_back({(k == 9), 8'(8'h41 + k)});
        src_q.push_back(9'h045); src_q.push_back(9'h0FC); src_q.push_back(9'h145);
        dir[0] = mk(0, 56'h0, 3'd0, 12'h000, 3'd0, 0, 8'h41, 12'h000, 3'd1, 0, 56'h41, 4'd0, 0);
        dir[1] = mk(1, 56'h48474645444342, 3'd7, 12'h005, 3'd4, 1, 8'h00, 12'h005, 3'd4, 0, 56'h45444342, 4'd5, 0);
        dir[2] = mk(1, 56'h4A49484746, 3'd5, 12'h010, 3'd1, 0, 8'h46, 12'h000, 3'd1, 0, 56'h46, 4'd0, 0);
        dir[3] = mk(1, 56'h4A494847, 3'd4, 12'h123, 3'd0, 0, 8'h47, 12'h000, 3'd1, 0, 56'h47, 4'd1, 0);
        dir[4] = mk(1, 56'h4A4948, 3'd3, 12'hABC, 3'd7, 1, 8'h00, 12'hABC, 3'd3, 1, 56'h4A4948, 4'd0, 1);
        dir[5] = mk(0, 56'h0, 3'd0, 12'h000, 3'd0, 0, 8'h45, 12'h000, 3'd1, 0, 56'h45, 4'd0, 1);
        dir[6] = mk(1, 56'h45FC, 3'd2, 12'h7FF, 3'd2, 1, 8'h00, 12'h7FF, 3'd2, 1, 56'h45FC, 4'd2, 1);
        fork
            run_source(0);
            begin
                for (int i = 0; i < 7; i++) apply_step(dir[i]);
            end
        join
        chk("pageB_busy", busy, 0);
        chk("pageB_in_ready", inDataReady, 1);

        build_random();
        fork
            run_source(1);
            begin
                foreach (steps[k]) apply_step(steps[k]);
            end
        join
        chk("rand_busy", busy, 0);

        // Reset while the first byte of a two-byte page is being committed.
        src_q.delete();
        src_q.push_back(9'h011); src_q.push_back(9'h122);
        fork
            run_source(0);
            begin
                wait_for(2, "rc_tok", saw);
                tokenReady = 1;
                @(negedge clock);
                tokenReady = 0;
            end
        join
        chk("rc_commit", searchWriteDataValid, 1);
        reset = 0;
        #1;
        chk("rc_valids", {searchPatternValid, searchResultReady, tokenValid, searchWriteDataValid}, 0);
        chk("rc_busy", busy, 0);
        chk("rc_in_ready_low", inDataReady, 0);
        @(negedge clock);
        reset = 1;
        #1;
        chk("rc_in_ready", inDataReady, 1);
        chk("rc_busy_rel", busy, 0);
        repeat (2) @(negedge clock);

        chk("onehot", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
